rf_read_ctrl: RTL

//  Read-side companion to the layer-controller register file. Accepts a block-read request
//  (start address, word count, remote destination), selects words from the packed RF bus one at a

---
 rtl/rf_read_ctrl_pkg.sv | 12 +
 rtl/rf_word_mux.sv | 16 +
 rtl/rf_read_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/rf_read_ctrl_pkg.sv
// rf_read_ctrl_pkg: RF geometry and read-controller FSM state encodings.
package rf_read_ctrl_pkg;
  localparam int LC_RF_DATA_WIDTH = 24;
  localparam int LC_RF_DEPTH = 256;
  typedef enum logic [2:0] {
    RFRD_IDLE     = 3'd0,
    RFRD_FETCH    = 3'd1,
    RFRD_SEND     = 3'd2,
    RFRD_RELEASE  = 3'd3,
    RFRD_WAIT_END = 3'd4
  } rfrd_state_t;
endpackage

// File: rtl/rf_word_mux.sv
// rf_word_mux: combinational DEPTH:1 word select from the packed RF bus.
module rf_word_mux #(
  parameter int DATA_W = 24,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input  logic [DATA_W*DEPTH-1:0] rf_din,
  input  logic [ADDR_W-1:0]       sel,
  output logic [DATA_W-1:0]       word
);
  logic [DATA_W-1:0] words [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_w
    assign words[i] = rf_din[DATA_W*i +: DATA_W];
  end
  assign word = words[sel];
endmodule

// File: rtl/rf_read_ctrl.sv
// rf_read_ctrl: block-reads RF words and streams them to MBus TX as {dest, data}.
// Define RF_READ_WRAP_EN to let rd_ptr wrap past DEPTH-1 instead of rejecting such requests.
module rf_read_ctrl
  import rf_read_ctrl_pkg::*;
#(
  parameter int DATA_W = LC_RF_DATA_WIDTH,
  parameter int DEPTH = LC_RF_DEPTH,
  parameter int ADDR_W = 8,
  parameter int LEN_W = 8
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic [DATA_W*DEPTH-1:0] RF_DIN,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [ADDR_W-1:0]       REQ_ADDR,
  input  logic [LEN_W-1:0]        REQ_LEN,
  input  logic [7:0]              REQ_DEST,
  output logic [8+DATA_W-1:0]     TX_DATA,
  output logic                    TX_PEND,
  output logic                    TX_REQ,
  input  logic                    TX_ACK,
  input  logic                    TX_SUCC,
  input  logic                    TX_FAIL,
  output logic                    DONE,
  output logic                    ERR
);
  rfrd_state_t state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [LEN_W-1:0] remain;
  logic [7:0] dest_ptr;
  logic [DATA_W-1:0] word;
  logic req_bad;
`ifdef RF_READ_WRAP_EN
  assign req_bad = 1'b0;
  assign ptr_nxt = (rd_ptr == ADDR_W'(DEPTH-1)) ? '0 : rd_ptr + ADDR_W'(1);
`else
  localparam int SUM_W = (ADDR_W > LEN_W ? ADDR_W : LEN_W) + 1;
  logic [SUM_W-1:0] end_addr;
  assign end_addr = SUM_W'(REQ_ADDR) + SUM_W'(REQ_LEN);
  assign req_bad = end_addr > SUM_W'(DEPTH-1);
  assign ptr_nxt = rd_ptr + ADDR_W'(1);
`endif
  assign REQ_READY = state == RFRD_IDLE;
  rf_word_mux #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mux (
    .rf_din(RF_DIN),
    .sel(rd_ptr),
    .word(word)
  );
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      state <= RFRD_IDLE;
      rd_ptr <= '0;
      remain <= '0;
      dest_ptr <= '0;
      TX_DATA <= '0;
      TX_PEND <= 1'b0;
      TX_REQ <= 1'b0;
      DONE <= 1'b0;
      ERR <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR <= 1'b0;
      // A bus abort wins over everything, including a simultaneous TX_SUCC
      if (state != RFRD_IDLE && TX_FAIL) begin
        TX_REQ <= 1'b0;
        ERR <= 1'b1;
        state <= RFRD_IDLE;
      end else
        case (state)
          RFRD_IDLE:
            if (REQ_VALID) begin
              if (req_bad) ERR <= 1'b1;
              else begin
                rd_ptr <= REQ_ADDR;
                remain <= REQ_LEN;
                dest_ptr <= REQ_DEST;
                state <= RFRD_FETCH;
              end
            end
          RFRD_FETCH: begin
            TX_DATA <= {dest_ptr, word};
            TX_PEND <= remain != '0;
            TX_REQ <= 1'b1;
            state <= RFRD_SEND;
          end
          RFRD_SEND:
            if (TX_ACK) begin
              TX_REQ <= 1'b0;
              state <= RFRD_RELEASE;
            end
          RFRD_RELEASE:
            if (!TX_ACK) begin
              if (remain == '0) state <= RFRD_WAIT_END;
              else begin
                remain <= remain - LEN_W'(1);
                rd_ptr <= ptr_nxt;
                dest_ptr <= dest_ptr + 8'd1;
                state <= RFRD_FETCH;
              end
            end
          RFRD_WAIT_END:
            if (TX_SUCC) begin
              DONE <= 1'b1;
              state <= RFRD_IDLE;
            end
          default: state <= RFRD_IDLE;
        endcase
    end
endmodule
